decode_stage_way0: RTL and testbench

Issue-side decode stage for pipeline way 0. It accepts one 32-bit RV64I instruction per cycle from fetch and decodes it. In the same cycle it drives the register-file read addresses and captures the returned operands. It presents a registered decoded bundle to the way-0 execute unit through a valid/ready handshake, and a two-entry skid buffer keeps fetch-side `ready_o` fully registered.

---
 rtl/decode_pkg.sv | 78 +++++++
 rtl/decode_imm_gen.sv | 27 ++
 rtl/decode_stage_way0.sv | 119 +++++++++++
 tb/tb_decode_stage_way0.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions for the way-0 decode stage: opcodes, immediate
// formats and the per-instruction decoded control fields.
package decode_pkg;

  localparam logic [6:0] OP_LUI     = 7'h37;
  localparam logic [6:0] OP_AUIPC   = 7'h17;
  localparam logic [6:0] OP_JAL     = 7'h6F;
  localparam logic [6:0] OP_JALR    = 7'h67;
  localparam logic [6:0] OP_BRANCH  = 7'h63;
  localparam logic [6:0] OP_LOAD    = 7'h03;
  localparam logic [6:0] OP_STORE   = 7'h23;
  localparam logic [6:0] OP_IMM     = 7'h13;
  localparam logic [6:0] OP_IMM_32  = 7'h1B;
  localparam logic [6:0] OP_OP      = 7'h33;
  localparam logic [6:0] OP_OP_32   = 7'h3B;
  localparam logic [6:0] OP_FENCE   = 7'h0F;
  localparam logic [6:0] OP_SYSTEM  = 7'h73;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic [4:0] rd_addr;
    logic       rd_we;
    logic       illegal;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] shamt;
  } dec_fields_t;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR,
      OP_FENCE, OP_SYSTEM:            fmt = FMT_I;
      OP_STORE:                       fmt = FMT_S;
      OP_BRANCH:                      fmt = FMT_B;
      OP_LUI, OP_AUIPC:               fmt = FMT_U;
      OP_JAL:                         fmt = FMT_J;
      default:                        fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  function automatic dec_fields_t decode_fields(input logic [31:0] inst);
    dec_fields_t d;
    logic        known;
    logic        writes_rd;
    known     = 1'b0;
    writes_rd = 1'b0;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM,
      OP_IMM_32, OP_OP, OP_OP_32, OP_SYSTEM: begin
        known     = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE, OP_FENCE: known = 1'b1;
      default: ;
    endcase
    d.rd_addr = inst[11:7];
    d.illegal = !known || (inst[1:0] != 2'b11);
    // x0 writes are dropped here so execute never sees a write-back to x0
    d.rd_we   = writes_rd && !d.illegal && (inst[11:7] != 5'd0);
    d.opcode  = inst[6:0];
    d.funct3  = inst[14:12];
    d.funct7  = inst[31:25];
    d.shamt   = inst[25:20];
    return d;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational immediate generator: assembles and sign-extends the
// immediate for the given format (bits [6:0] of the instruction are not needed).
module decode_imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:7]     inst,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      FMT_S: imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: imm = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25],
                    inst[11:8], 1'b0};
      FMT_U: imm = {{(XLEN-32){inst[31]}}, inst[31:12], 12'h000};
      FMT_J: imm = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20],
                    inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage_way0.sv
// Way-0 decode stage: decodes one instruction per cycle, captures register
// operands and hands a registered bundle to execute through a 2-entry skid.
module decode_stage_way0
  import decode_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] instAddr_i,
  input  logic [31:0]       inst_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [4:0]        rs1Addr_o,
  output logic [4:0]        rs2Addr_o,
  input  logic [XLEN-1:0]   rs1ReadData_i,
  input  logic [XLEN-1:0]   rs2ReadData_i,
  output logic [ADDR_W-1:0] instAddr_o,
  output logic [31:0]       inst_o,
  output logic [4:0]        rdAddr_o,
  output logic              rdWriteEnable_o,
  output logic [XLEN-1:0]   rs1ReadData_o,
  output logic [XLEN-1:0]   rs2ReadData_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [6:0]        opCode_o,
  output logic [2:0]        funct3_o,
  output logic [6:0]        funct7_o,
  output logic [5:0]        shamt_o,
  output logic              illegal_o,
  output logic              valid_o,
  input  logic              ready_i
);

  typedef struct packed {
    logic [ADDR_W-1:0] inst_addr;
    logic [31:0]       inst;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    dec_fields_t       dec;
  } bundle_t;

  bundle_t         out_reg;
  bundle_t         skid_reg;
  bundle_t         in_bundle;
  logic            out_valid_reg;
  logic            skid_valid_reg;
  imm_fmt_e        in_fmt;
  logic [XLEN-1:0] in_imm;
  logic            accept;
  logic            consume;

  assign rs1Addr_o = inst_i[19:15];
  assign rs2Addr_o = inst_i[24:20];
  assign in_fmt    = imm_fmt_of(inst_i[6:0]);

  decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (inst_i[31:7]),
    .fmt  (in_fmt),
    .imm  (in_imm)
  );

  always_comb begin
    in_bundle           = '0;
    in_bundle.inst_addr = instAddr_i;
    in_bundle.inst      = inst_i;
    in_bundle.rs1_data  = rs1ReadData_i;
    in_bundle.rs2_data  = rs2ReadData_i;
    in_bundle.imm       = in_imm;
    in_bundle.dec       = decode_fields(inst_i);
  end

  // ready_o comes straight from a flop, so fetch sees backpressure a cycle late
  assign ready_o = !skid_valid_reg;
  assign accept  = valid_i && ready_o;
  assign consume = out_valid_reg && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg        <= '0;
      skid_reg       <= '0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (flush_i) begin
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!out_valid_reg || consume) begin
      if (skid_valid_reg) begin
        out_reg        <= skid_reg;
        out_valid_reg  <= 1'b1;
        skid_valid_reg <= accept;
        if (accept) skid_reg <= in_bundle;
      end else begin
        out_valid_reg <= accept;
        if (accept) out_reg <= in_bundle;
      end
    end else if (accept) begin
      skid_reg       <= in_bundle;
      skid_valid_reg <= 1'b1;
    end
  end

  assign valid_o         = out_valid_reg;
  assign instAddr_o      = out_reg.inst_addr;
  assign inst_o          = out_reg.inst;
  assign rs1ReadData_o   = out_reg.rs1_data;
  assign rs2ReadData_o   = out_reg.rs2_data;
  assign imm_o           = out_reg.imm;
  assign rdAddr_o        = out_reg.dec.rd_addr;
  assign rdWriteEnable_o = out_reg.dec.rd_we;
  assign illegal_o       = out_reg.dec.illegal;
  assign opCode_o        = out_reg.dec.opcode;
  assign funct3_o        = out_reg.dec.funct3;
  assign funct7_o        = out_reg.dec.funct7;
  assign shamt_o         = out_reg.dec.shamt;

endmodule

// File: tb/tb_decode_stage_way0.sv
// Self-checking bench for decode_stage_way0: directed scenarios plus random
// traffic checked against a 2-deep FIFO reference model.
module tb_decode_stage_way0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] instAddr_i = '0;
  logic [31:0] inst_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  rs1Addr_o, rs2Addr_o;
  logic [63:0] rs1ReadData_i = '0, rs2ReadData_i = '0;
  logic [31:0] instAddr_o, inst_o;
  logic [4:0]  rdAddr_o;
  logic        rdWriteEnable_o;
  logic [63:0] rs1ReadData_o, rs2ReadData_o, imm_o;
  logic [6:0]  opCode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [5:0]  shamt_o;
  logic        illegal_o, valid_o;
  logic        ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_way0 dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .instAddr_i(instAddr_i), .inst_i(inst_i), .valid_i(valid_i), .ready_o(ready_o),
    .rs1Addr_o(rs1Addr_o), .rs2Addr_o(rs2Addr_o),
    .rs1ReadData_i(rs1ReadData_i), .rs2ReadData_i(rs2ReadData_i),
    .instAddr_o(instAddr_o), .inst_o(inst_o), .rdAddr_o(rdAddr_o),
    .rdWriteEnable_o(rdWriteEnable_o), .rs1ReadData_o(rs1ReadData_o),
    .rs2ReadData_o(rs2ReadData_o), .imm_o(imm_o), .opCode_o(opCode_o),
    .funct3_o(funct3_o), .funct7_o(funct7_o), .shamt_o(shamt_o),
    .illegal_o(illegal_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  // Reference model: the stage behaves as a FIFO holding at most two entries.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [63:0] a;
    logic [63:0] b;
  } entry_t;
  entry_t q[$];

  function automatic logic [63:0] exp_imm(input logic [31:0] i);
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [31:0] u32;
    logic signed [20:0] j21;
    longint r;
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    u32 = {i[31:12], 12'h000};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h0F, 7'h73: begin i12 = i[31:20]; r = i12; end
      7'h23: begin i12 = {i[31:25], i[11:7]}; r = i12; end
      7'h63: r = b13;
      7'h37, 7'h17: r = u32;
      7'h6F: r = j21;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic logic [285:0] exp_vec(input entry_t e);
    logic [6:0] op;
    logic ill, we;
    op  = e.inst[6:0];
    ill = !(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                       7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73});
    we  = (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h1B,
                      7'h33, 7'h3B, 7'h73}) && (e.inst[11:7] != 5'd0);
    return {e.pc, e.inst, e.inst[11:7], we, e.a, e.b, exp_imm(e.inst),
            op, e.inst[14:12], e.inst[31:25], e.inst[25:20], ill};
  endfunction

  function automatic logic [285:0] act_vec();
    return {instAddr_o, inst_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o,
            rs2ReadData_o, imm_o, opCode_o, funct3_o, funct7_o, shamt_o, illegal_o};
  endfunction

  function automatic void model_update();
    bit acc, cons;
    acc  = valid_i && (q.size() < 2);
    cons = (q.size() > 0) && ready_i;
    if (flush_i) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(entry_t'{instAddr_i, inst_i, rs1ReadData_i, rs2ReadData_i});
    end
  endfunction

  // Drives one cycle of inputs (called near the falling edge), returns at the next falling edge.
  task automatic drive_cycle(input logic v, input logic [31:0] ins,
                             input logic rdy, input logic fl);
    valid_i       = v;
    inst_i        = ins;
    ready_i       = rdy;
    flush_i       = fl;
    instAddr_i    = $urandom;
    rs1ReadData_i = {$urandom, $urandom};
    rs2ReadData_i = {$urandom, $urandom};
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || act_vec() !== '0) begin
      errors++;
      $display("FAIL reset_state valid=%b ready=%b bundle=%h required valid=0 ready=1 bundle=0",
               valid_o, ready_o, act_vec());
    end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset released: valid=%b ready=%b", valid_o, ready_o);
  endtask

  task automatic test_decode();
    drive_cycle(1, 32'hFFF00293, 1, 0);
    checks++;
    if (valid_o !== 1'b1 || opCode_o !== 7'h13 || rdAddr_o !== 5'd5 ||
        rdWriteEnable_o !== 1'b1 || imm_o !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL addi valid=%b op=%h rd=%0d we=%b imm=%h required 1 13 5 1 ffffffffffffffff",
               valid_o, opCode_o, rdAddr_o, rdWriteEnable_o, imm_o);
    end
    $display("addi: op=%h rd=%0d we=%b imm=%h", opCode_o, rdAddr_o, rdWriteEnable_o, imm_o);
    drive_cycle(1, 32'hFE208EE3, 1, 0);
    checks++;
    if (imm_o !== 64'hFFFF_FFFF_FFFF_FFFC || rdWriteEnable_o !== 1'b0 ||
        rs1Addr_o !== 5'd1 || rs2Addr_o !== 5'd2) begin
      errors++;
      $display("FAIL beq imm=%h we=%b rs1=%0d rs2=%0d required fffffffffffffffc 0 1 2",
               imm_o, rdWriteEnable_o, rs1Addr_o, rs2Addr_o);
    end
    $display("beq: imm=%h we=%b rs1=%0d rs2=%0d", imm_o, rdWriteEnable_o, rs1Addr_o, rs2Addr_o);
    drive_cycle(1, 32'h03F19193, 1, 0);
    checks++;
    if (shamt_o !== 6'd63) begin
      errors++;
      $display("FAIL slli_shamt got=%0d required=63", shamt_o);
    end
    $display("slli: shamt=%0d", shamt_o);
    drive_cycle(1, 32'h800000B7, 1, 0);
    checks++;
    if (imm_o !== 64'hFFFF_FFFF_8000_0000 || rdAddr_o !== 5'd1 || rdWriteEnable_o !== 1'b1) begin
      errors++;
      $display("FAIL lui imm=%h rd=%0d we=%b required ffffffff80000000 1 1",
               imm_o, rdAddr_o, rdWriteEnable_o);
    end
    $display("lui: imm=%h", imm_o);
    drive_cycle(0, 32'h0, 1, 0);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid got=%b required=0", valid_o);
    end
  endtask

  task automatic test_illegal();
    drive_cycle(1, 32'h0000_0000, 1, 0);
    checks++;
    if (valid_o !== 1'b1 || illegal_o !== 1'b1 || rdWriteEnable_o !== 1'b0 || imm_o !== 64'd0) begin
      errors++;
      $display("FAIL illegal_zero valid=%b ill=%b we=%b imm=%h required 1 1 0 0",
               valid_o, illegal_o, rdWriteEnable_o, imm_o);
    end
    drive_cycle(1, 32'h0000_02B1, 1, 0);  // bits[1:0]=01 with rd=5
    checks++;
    if (illegal_o !== 1'b1 || rdWriteEnable_o !== 1'b0) begin
      errors++;
      $display("FAIL illegal_lowbits ill=%b we=%b required 1 0", illegal_o, rdWriteEnable_o);
    end
    $display("illegal: ill=%b we=%b", illegal_o, rdWriteEnable_o);
    drive_cycle(0, 32'h0, 1, 0);
  endtask

  task automatic test_backpressure();
    logic [31:0] ia, ib, ic;
    ia = 32'h00100093; ib = 32'h00200113; ic = 32'h00300193;
    drive_cycle(1, ia, 0, 0);
    drive_cycle(1, ib, 0, 0);
    checks++;
    if (ready_o !== 1'b0 || inst_o !== ia) begin
      errors++;
      $display("FAIL bp_full ready=%b inst=%h required 0 %h", ready_o, inst_o, ia);
    end
    drive_cycle(1, ic, 0, 0);
    checks++;
    if (ready_o !== 1'b0 || inst_o !== ia || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold ready=%b inst=%h valid=%b required 0 %h 1", ready_o, inst_o, valid_o, ia);
    end
    drive_cycle(1, ic, 1, 0);
    checks++;
    if (inst_o !== ib || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_second inst=%h ready=%b required %h 1", inst_o, ready_o, ib);
    end
    drive_cycle(1, ic, 1, 0);
    checks++;
    if (inst_o !== ic || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_third inst=%h valid=%b required %h 1", inst_o, valid_o, ic);
    end
    drive_cycle(0, 32'h0, 1, 0);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup valid=%b required 0", valid_o);
    end
    $display("backpressure: order a,b,c delivered");
  endtask

  task automatic test_simultaneous();
    logic [31:0] ia, ib, id;
    ia = 32'h00A00513; ib = 32'h00B00593; id = 32'h00C00613;
    drive_cycle(1, ia, 0, 0);
    drive_cycle(1, ib, 0, 0);
    drive_cycle(1, id, 1, 0);
    checks++;
    if (inst_o !== ib || valid_o !== 1'b1 || ready_o !== (q.size() < 2)) begin
      errors++;
      $display("FAIL simul_move inst=%h valid=%b ready=%b required %h 1 %b",
               inst_o, valid_o, ready_o, ib, (q.size() < 2));
    end
    drive_cycle(1, id, 0, 0);
    drive_cycle(0, 32'h0, 1, 0);
    checks++;
    if (inst_o !== id || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL simul_new inst=%h valid=%b required %h 1", inst_o, valid_o, id);
    end
    drive_cycle(0, 32'h0, 1, 0);
    $display("simultaneous: skid moved, new entry kept");
  endtask

  task automatic test_flush();
    drive_cycle(1, 32'h00D00693, 0, 0);
    drive_cycle(1, 32'h00E00713, 0, 0);
    drive_cycle(1, 32'h00F00793, 0, 1);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL flush valid=%b ready=%b required 0 1", valid_o, ready_o);
    end
    drive_cycle(0, 32'h0, 1, 0);
    checks++;
    if (valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard valid=%b inst=%h required valid 0", valid_o, inst_o);
    end
    $display("flush: valid=%b ready=%b", valid_o, ready_o);
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 32'h01000813, 0, 0);
    drive_cycle(1, 32'h01100893, 0, 0);
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || act_vec() !== '0) begin
      errors++;
      $display("FAIL async_reset valid=%b ready=%b bundle=%h required 0 1 0",
               valid_o, ready_o, act_vec());
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    $display("async reset: valid=%b ready=%b", valid_o, ready_o);
  endtask

  task automatic test_random();
    logic [6:0]  ops [14];
    logic [31:0] r, ins;
    logic        exp_rdy;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
            7'h13, 7'h1B, 7'h33, 7'h3B, 7'h0F, 7'h73, 7'h0B};
    for (int n = 0; n < 300; n++) begin
      r   = $urandom;
      ins = {r[31:7], ops[$urandom_range(13)]};
      if ($urandom_range(15) == 0) ins = $urandom;
      drive_cycle($urandom_range(3) != 0, ins, $urandom_range(2) != 0,
                  $urandom_range(40) == 0);
      exp_rdy = (q.size() < 2);
      checks++;
      if (ready_o !== exp_rdy || valid_o !== (q.size() > 0)) begin
        errors++;
        $display("FAIL rand_ctrl cyc=%0d ready=%b valid=%b required %b %b",
                 n, ready_o, valid_o, exp_rdy, (q.size() > 0));
      end
      if (q.size() > 0) begin
        checks++;
        if (act_vec() !== exp_vec(q[0])) begin
          errors++;
          $display("FAIL rand_bundle cyc=%0d got=%h required=%h", n, act_vec(), exp_vec(q[0]));
        end
      end
    end
    $display("random: %0d cycles done", 300);
  endtask

  initial begin
    test_reset();
    test_decode();
    test_illegal();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
